mu0_control: RTL

- Control unit for the MU0 core. It drives every datapath select, enable and ALU-mode line from the opcode (F) and the flags (N, Z).
- It sequences a two-phase fetch/execute cycle.
- It runs a memory read/write handshake with wait states and a bus timeout.
- It sits beside the MU0 datapath in the MU0 top level, between the datapath and the memory/bus.

---
 rtl/mu0_pkg.sv | 42 ++++
 rtl/mu0_wait_timer.sv | 28 ++
 rtl/mu0_control.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mu0_pkg.sv
// Shared constants and types for the MU0 control unit: opcodes, ALU modes,
// FSM state encoding and the bundle of datapath control lines.
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] M_Y   = 2'b00;
  localparam logic [1:0] M_ADD = 2'b01;
  localparam logic [1:0] M_INC = 2'b10;
  localparam logic [1:0] M_SUB = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_HALT  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  typedef struct packed {
    logic       x_sel;
    logic       y_sel;
    logic       addr_sel;
    logic       pc_en;
    logic       ir_en;
    logic       acc_en;
    logic [1:0] m;
    logic       rd;
    logic       wr;
  } ctrl_t;

  // Opcodes 0..3 (LDA, STA, ADD, SUB) touch memory during EXEC.
  function automatic logic is_mem_op(input logic [3:0] f);
    return (f[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/mu0_wait_timer.sv
// Counts consecutive stalled cycles of a bus access and strobes timeout on the
// stalled cycle whose edge would bring the count to TIMEOUT.
module mu0_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic timeout
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign timeout = count && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute sequencer, opcode decode to datapath
// control lines, and a memory handshake with wait states and bus timeout.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       Mem_Ready,
  input  logic       Resume,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic [1:0] M,
  output logic       Rd,
  output logic       Wr,
  output logic       Halted,
  output logic       Fault,
  output logic [2:0] state
);

  logic [2:0] state_r;
  logic [2:0] nxt;
  ctrl_t      ctrl;
  logic       pending;
  logic       timeout;

  // Handshake: Rd/Wr are held high on every cycle of a pending access; the
  // access completes on a cycle where Mem_Ready=1, and only that cycle may
  // assert register enables. Consecutive Mem_Ready=0 cycles count toward timeout.
  assign pending = (state_r == S_FETCH) || ((state_r == S_EXEC) && is_mem_op(F));

  mu0_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .TW     (TW)
  ) u_wait_timer (
    .clk    (Clk),
    .rst_n  (Reset),
    .clear  (!pending || Mem_Ready),
    .count  (pending && !Mem_Ready),
    .timeout(timeout)
  );

  always_comb begin
    ctrl = '0;
    nxt  = state_r;
    case (state_r)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        ctrl.rd    = 1'b1;
        ctrl.x_sel = 1'b1;
        ctrl.m     = M_INC;
        if (Mem_Ready) begin
          ctrl.ir_en = 1'b1;
          ctrl.pc_en = 1'b1;
          nxt        = S_EXEC;
        end else if (timeout) begin
          nxt = S_FAULT;
        end
      end
      S_EXEC: begin
        nxt = S_FETCH;
        case (F)
          OP_LDA: begin
            ctrl.addr_sel = 1'b1;
            ctrl.rd       = 1'b1;
            ctrl.m        = M_Y;
            ctrl.acc_en   = Mem_Ready;
          end
          OP_STA: begin
            ctrl.addr_sel = 1'b1;
            ctrl.wr       = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.addr_sel = 1'b1;
            ctrl.rd       = 1'b1;
            ctrl.m        = (F == OP_ADD) ? M_ADD : M_SUB;
            ctrl.acc_en   = Mem_Ready;
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            ctrl.y_sel = 1'b1;
            ctrl.m     = M_Y;
            ctrl.pc_en = (F == OP_JMP) ? 1'b1 : (F == OP_JGE) ? ~N : ~Z;
          end
          OP_STP:  nxt = S_HALT;
          default: ;
        endcase
        if (is_mem_op(F) && !Mem_Ready) begin
          nxt = timeout ? S_FAULT : S_EXEC;
        end
      end
      S_HALT:  if (Resume) nxt = S_FETCH;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= nxt;
    end
  end

  assign X_sel    = ctrl.x_sel;
  assign Y_sel    = ctrl.y_sel;
  assign Addr_sel = ctrl.addr_sel;
  assign PC_En    = ctrl.pc_en;
  assign IR_En    = ctrl.ir_en;
  assign Acc_En   = ctrl.acc_en;
  assign M        = ctrl.m;
  assign Rd       = ctrl.rd;
  assign Wr       = ctrl.wr;
  assign Halted   = (state_r == S_HALT);
  assign Fault    = (state_r == S_FAULT);
  assign state    = state_r;

endmodule
